multicycle_ctrl: RTL and testbench
==================================

// Module: multicycle_ctrl
// PURPOSE
//  Moore FSM sequencing the RV32I multicycle datapath: fetch, decode, execute, memory, writeback.
//  Drives imm_sel into the immediate generator mux, ALU operand selects, register/PC write enables
//  and imem/dmem req/ready handshakes. Counts retired instructions. Sits beside the IR/PC/regfile.
// PARAMETERS
//  RETIRE_W   32   width of retired-instruction counter (wraps modulo 2**RETIRE_W)
// PORTS
//  clk          in   1        rising-edge clock
//  rst_n        in   1        asynchronous active-low reset
//  imem_req     out  1        instruction fetch request; held until imem_ready
//  imem_ready   in   1        fetch data valid this cycle
//  ir_we        out  1        latch instruction into IR (1-cycle pulse)
//  ir_opcode    in   7        IR[6:0], valid from DECODE onward
//  branch_taken in   1        branch comparator result, sampled in EXEC
//  dmem_req     out  1        data memory request; held until dmem_ready
//  dmem_we      out  1        1=store, 0=load; valid while dmem_req
//  dmem_ready   in   1        data access complete this cycle
//  imm_sel      out  3        imm_sel_e: I,S,B,U,J (LUI/AUIPC share U; JALR uses I)
//  alu_src_a    out  2        0=rs1 1=pc 2=zero
//  alu_src_b    out  1        0=rs2 1=imm
//  alu_mode     out  2        0=ADD 1=FUNCT(funct3/7) 2=CMP
//  reg_we       out  1        regfile write (1-cycle pulse in WB)
//  wb_sel       out  2        0=ALU 1=MEM 2=PC+4
//  pc_we        out  1        PC update (1-cycle pulse, last state of instr)
//  pc_sel       out  2        0=PC+4 1=PC+imm 2=ALU&~1
//  retired_cnt  out  RETIRE_W instructions completed
// BEHAVIOUR
//  States: IDLE, FETCH, DECODE, EXEC, MEM, WB (+TRAP with macro). Reset -> IDLE; all outputs 0,
//   retired_cnt 0. IDLE -> FETCH unconditionally next cycle.
//  FETCH: imem_req=1 until imem_ready; that cycle ir_we=1, -> DECODE. imem_ready outside FETCH ignored.
//  DECODE: imm_sel from opcode; 1 cycle -> EXEC.
//  EXEC by opcode: OP/OP-IMM/LUI/AUIPC -> WB (wb_sel ALU). LOAD/STORE -> MEM (alu ADD rs1+imm).
//   BRANCH: alu_mode CMP, pc_we=1, pc_sel = branch_taken?1:0, retire, -> FETCH.
//   JAL: pc_we=1 pc_sel=1 -> WB(wb_sel PC+4). JALR: pc_we=1 pc_sel=2 -> WB(wb_sel PC+4).
//  MEM: dmem_req=1, dmem_we=(STORE) until dmem_ready. Store: pc_we(PC+4), retire, -> FETCH.
//   Load: -> WB wb_sel MEM.
//  WB: reg_we=1 for 1 cycle; pc_we(PC+4) unless JAL/JALR already wrote PC; retire; -> FETCH.
//  Min latency (ready same cycle): branch 3, ALU/LUI/AUIPC/JAL/JALR/store 4, load 5 cycles.
//  retired_cnt +1 on each completing cycle; wraps to 0 from all-ones, no flag.
//  ready held low: FSM stalls indefinitely, req held, all other enables 0.
//  Async reset mid-access: req dropped immediately, state IDLE, access abandoned, counter cleared.
//  Unknown opcode (no macro): treated as NOP: EXEC pc_we PC+4, retire, -> FETCH.
// CONFIGURATION
//  MULTICYCLE_CTRL_TRAP_EN defined: unknown opcode in EXEC -> TRAP; output trap (1b) =1 while
//   in TRAP, no pc_we, no retire; TRAP exits only by reset. Undefined: no trap port, NOP rule.
// STRUCTURE
//  Package riscv_ctrl_pkg: opcode localparams, ctrl_state_e, imm_sel_e, wb_sel_e, pc_sel_e.
//  Sub-module ctrl_opcode_dec (comb): opcode -> instr class + imm_sel; FSM stays in top.
// TESTING
//  Reset release, imem_ready=1, ADDI (0x13) -> FETCH..WB in 4 cycles, reg_we 1 cycle, retired_cnt 1.
//  LW (0x03), dmem_ready delayed 3 cycles -> dmem_req held 4 cycles dmem_we=0, wb_sel=1, total 8 cycles.
//  SW (0x23) -> imm_sel=S, dmem_we=1, no reg_we, pc_sel=0.
//  BEQ (0x63) branch_taken=1 -> pc_we in EXEC, pc_sel=1; taken=0 -> pc_sel=0; 3 cycles each.
//  JALR (0x67) -> EXEC pc_sel=2; WB wb_sel=2, reg_we=1, no second pc_we.
//  rst_n low mid-MEM -> dmem_req 0 same cycle, outputs 0; opcode 0x7F: NOP, or trap=1 with macro.

Source files
------------

// File: rtl/riscv_ctrl_pkg.sv
// Shared types for the RV32I multicycle control unit:
// opcodes, FSM states, mux select encodings and the decoder bundle.
package riscv_ctrl_pkg;

  localparam logic [6:0] OPC_LOAD   = 7'h03;
  localparam logic [6:0] OPC_OPIMM  = 7'h13;
  localparam logic [6:0] OPC_AUIPC  = 7'h17;
  localparam logic [6:0] OPC_STORE  = 7'h23;
  localparam logic [6:0] OPC_OP     = 7'h33;
  localparam logic [6:0] OPC_LUI    = 7'h37;
  localparam logic [6:0] OPC_BRANCH = 7'h63;
  localparam logic [6:0] OPC_JALR   = 7'h67;
  localparam logic [6:0] OPC_JAL    = 7'h6F;

  localparam logic [1:0] SRC_A_RS1  = 2'd0;
  localparam logic [1:0] SRC_A_PC   = 2'd1;
  localparam logic [1:0] SRC_A_ZERO = 2'd2;
  localparam logic       SRC_B_RS2  = 1'b0;
  localparam logic       SRC_B_IMM  = 1'b1;
  localparam logic [1:0] ALU_ADD    = 2'd0;
  localparam logic [1:0] ALU_FUNCT  = 2'd1;
  localparam logic [1:0] ALU_CMP    = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP
  } ctrl_state_e;

  typedef enum logic [2:0] {
    IMM_I, IMM_S, IMM_B, IMM_U, IMM_J
  } imm_sel_e;

  typedef enum logic [1:0] {
    WB_ALU, WB_MEM, WB_PC4
  } wb_sel_e;

  typedef enum logic [1:0] {
    PC_4, PC_IMM, PC_ALU
  } pc_sel_e;

  typedef enum logic [2:0] {
    CLS_ALU, CLS_LOAD, CLS_STORE, CLS_BRANCH,
    CLS_JAL, CLS_JALR, CLS_BAD
  } instr_cls_e;

  typedef struct packed {
    instr_cls_e cls;
    imm_sel_e   imm;
    logic [1:0] src_a;
    logic       src_b;
    logic [1:0] mode;
  } dec_t;

endpackage

// File: rtl/ctrl_opcode_dec.sv
// Combinational opcode decoder: instruction class,
// immediate format and ALU operand/mode selects.
module ctrl_opcode_dec
  import riscv_ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  output dec_t       dec
);

  always_comb begin
    dec = '{cls: CLS_BAD, imm: IMM_I, src_a: SRC_A_RS1,
            src_b: SRC_B_RS2, mode: ALU_ADD};
    unique case (1'b1)
      opcode == OPC_OP: begin
        dec.cls  = CLS_ALU;
        dec.mode = ALU_FUNCT;
      end
      opcode == OPC_OPIMM: begin
        dec.cls   = CLS_ALU;
        dec.src_b = SRC_B_IMM;
        dec.mode  = ALU_FUNCT;
      end
      opcode == OPC_LUI: begin
        dec.cls   = CLS_ALU;
        dec.imm   = IMM_U;
        dec.src_a = SRC_A_ZERO;
        dec.src_b = SRC_B_IMM;
      end
      opcode == OPC_AUIPC: begin
        dec.cls   = CLS_ALU;
        dec.imm   = IMM_U;
        dec.src_a = SRC_A_PC;
        dec.src_b = SRC_B_IMM;
      end
      opcode == OPC_LOAD: begin
        dec.cls   = CLS_LOAD;
        dec.src_b = SRC_B_IMM;
      end
      opcode == OPC_STORE: begin
        dec.cls   = CLS_STORE;
        dec.imm   = IMM_S;
        dec.src_b = SRC_B_IMM;
      end
      opcode == OPC_BRANCH: begin
        dec.cls  = CLS_BRANCH;
        dec.imm  = IMM_B;
        dec.mode = ALU_CMP;
      end
      opcode == OPC_JAL: begin
        dec.cls   = CLS_JAL;
        dec.imm   = IMM_J;
        dec.src_a = SRC_A_PC;
        dec.src_b = SRC_B_IMM;
      end
      opcode == OPC_JALR: begin
        dec.cls   = CLS_JALR;
        dec.src_b = SRC_B_IMM;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// RV32I multicycle control FSM with retired-instruction counter.
// Define MULTICYCLE_CTRL_TRAP_EN to trap on unknown opcodes.
module multicycle_ctrl
  import riscv_ctrl_pkg::*;
#(
  parameter int unsigned RETIRE_W = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  output logic                imem_req,
  input  logic                imem_ready,
  output logic                ir_we,
  input  logic [6:0]          ir_opcode,
  input  logic                branch_taken,
  output logic                dmem_req,
  output logic                dmem_we,
  input  logic                dmem_ready,
  output logic [2:0]          imm_sel,
  output logic [1:0]          alu_src_a,
  output logic                alu_src_b,
  output logic [1:0]          alu_mode,
  output logic                reg_we,
  output logic [1:0]          wb_sel,
  output logic                pc_we,
  output logic [1:0]          pc_sel,
  output logic [RETIRE_W-1:0] retired_cnt
`ifdef MULTICYCLE_CTRL_TRAP_EN
  ,
  output logic                trap
`endif
);

`ifdef MULTICYCLE_CTRL_TRAP_EN
  localparam logic TRAP_EN = 1'b1;
`else
  localparam logic TRAP_EN = 1'b0;
`endif

  ctrl_state_e state;
  instr_cls_e  cls;
  dec_t        dec;
  logic        br_q;
  logic        pc_we_q;
  logic [1:0]  pc_sel_q;
  logic        st_done;
  logic        retire;

  ctrl_opcode_dec u_dec (
    .opcode(ir_opcode),
    .dec   (dec)
  );

  // Handshake-completing strobes are qualified by ready
  assign ir_we   = imem_req & imem_ready;
  assign st_done = dmem_req & dmem_we & dmem_ready;
  assign pc_we   = pc_we_q | st_done;
  assign pc_sel  = br_q ? {1'b0, branch_taken} : pc_sel_q;

  assign imm_sel = (state inside {S_DECODE, S_EXEC, S_MEM, S_WB})
                 ? dec.imm : IMM_I;

  assign retire = (state == S_WB) | st_done
                | ((state == S_EXEC) & (cls == CLS_BRANCH))
                | ((state == S_EXEC) & (cls == CLS_BAD) & ~TRAP_EN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      cls         <= CLS_BAD;
      imem_req    <= 1'b0;
      dmem_req    <= 1'b0;
      dmem_we     <= 1'b0;
      alu_src_a   <= '0;
      alu_src_b   <= 1'b0;
      alu_mode    <= '0;
      reg_we      <= 1'b0;
      wb_sel      <= '0;
      pc_we_q     <= 1'b0;
      pc_sel_q    <= '0;
      br_q        <= 1'b0;
      retired_cnt <= '0;
`ifdef MULTICYCLE_CTRL_TRAP_EN
      trap        <= 1'b0;
`endif
    end else begin
      imem_req  <= 1'b0;
      dmem_req  <= 1'b0;
      dmem_we   <= 1'b0;
      alu_src_a <= '0;
      alu_src_b <= 1'b0;
      alu_mode  <= '0;
      reg_we    <= 1'b0;
      wb_sel    <= '0;
      pc_we_q   <= 1'b0;
      pc_sel_q  <= '0;
      br_q      <= 1'b0;
      if (retire) retired_cnt <= retired_cnt + RETIRE_W'(1);
      unique case (state)
        S_IDLE: begin
          state    <= S_FETCH;
          imem_req <= 1'b1;
        end
        S_FETCH: begin
          if (imem_ready) state <= S_DECODE;
          else imem_req <= 1'b1;
        end
        S_DECODE: begin
          state     <= S_EXEC;
          cls       <= dec.cls;
          alu_src_a <= dec.src_a;
          alu_src_b <= dec.src_b;
          alu_mode  <= dec.mode;
          unique case (dec.cls)
            CLS_BRANCH: begin
              pc_we_q <= 1'b1;
              br_q    <= 1'b1;
            end
            CLS_JAL: begin
              pc_we_q  <= 1'b1;
              pc_sel_q <= PC_IMM;
            end
            CLS_JALR: begin
              pc_we_q  <= 1'b1;
              pc_sel_q <= PC_ALU;
            end
            CLS_BAD: pc_we_q <= ~TRAP_EN;
            default: ;
          endcase
        end
        S_EXEC: begin
          unique case (cls)
            CLS_ALU: begin
              state   <= S_WB;
              reg_we  <= 1'b1;
              pc_we_q <= 1'b1;
            end
            CLS_LOAD, CLS_STORE: begin
              state    <= S_MEM;
              dmem_req <= 1'b1;
              dmem_we  <= (cls == CLS_STORE);
            end
            CLS_JAL, CLS_JALR: begin
              state  <= S_WB;
              reg_we <= 1'b1;
              wb_sel <= WB_PC4;
            end
            CLS_BRANCH: begin
              state    <= S_FETCH;
              imem_req <= 1'b1;
            end
            default: begin
`ifdef MULTICYCLE_CTRL_TRAP_EN
              state <= S_TRAP;
              trap  <= 1'b1;
`else
              state    <= S_FETCH;
              imem_req <= 1'b1;
`endif
            end
          endcase
        end
        S_MEM: begin
          if (!dmem_ready) begin
            dmem_req <= 1'b1;
            dmem_we  <= dmem_we;
          end else if (dmem_we) begin
            state    <= S_FETCH;
            imem_req <= 1'b1;
          end else begin
            state   <= S_WB;
            reg_we  <= 1'b1;
            pc_we_q <= 1'b1;
            wb_sel  <= WB_MEM;
          end
        end
        S_WB: begin
          state    <= S_FETCH;
          imem_req <= 1'b1;
        end
        S_TRAP: state <= S_TRAP;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: vector table,
// randomized instruction stream and reset/trap corner cases.
module tb_multicycle_ctrl;

  localparam int RW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          imem_req, imem_ready = 1'b0, ir_we;
  logic [6:0]    ir_opcode = 7'h13;
  logic          branch_taken = 1'b0;
  logic          dmem_req, dmem_we, dmem_ready = 1'b0;
  logic [2:0]    imm_sel;
  logic [1:0]    alu_src_a, alu_mode, wb_sel, pc_sel;
  logic          alu_src_b, reg_we, pc_we;
  logic [RW-1:0] retired_cnt;
`ifdef MULTICYCLE_CTRL_TRAP_EN
  logic          trap;
`endif

  multicycle_ctrl #(.RETIRE_W(RW)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_ready(imem_ready),
    .ir_we(ir_we), .ir_opcode(ir_opcode),
    .branch_taken(branch_taken),
    .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_ready(dmem_ready), .imm_sel(imm_sel),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_mode(alu_mode), .reg_we(reg_we),
    .wb_sel(wb_sel), .pc_we(pc_we), .pc_sel(pc_sel),
    .retired_cnt(retired_cnt)
`ifdef MULTICYCLE_CTRL_TRAP_EN
    , .trap(trap)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [6:0] opc;
    int tk, idl, mdl;
    int cycles, nreg, wb, psel, dcyc, dwe, imm;
  } exp_t;

  typedef struct {
    int cycles, nirwe, nreg, npc, dcyc;
    int wb, psel, dwe, imm, timeout;
  } obs_t;

  int checks = 0;
  int failures = 0;
  int model_cnt = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Expected behaviour from the instruction-class rules
  function automatic exp_t model(input logic [6:0] opc, input int tk,
                                 input int idl, input int mdl);
    exp_t e;
    int f;
    f = 1 + idl;
    e = '{opc: opc, tk: tk, idl: idl, mdl: mdl, default: 0};
    case (opc)
      7'h13, 7'h33: e.cycles = f + 3;
      7'h37, 7'h17: begin e.cycles = f + 3; e.imm = 3; end
      7'h03: begin
        e.cycles = f + 4 + mdl; e.wb = 1; e.dcyc = 1 + mdl;
      end
      7'h23: begin
        e.cycles = f + 3 + mdl; e.dcyc = 1 + mdl;
        e.dwe = 1; e.imm = 1;
      end
      7'h63: begin e.cycles = f + 2; e.psel = tk; e.imm = 2; end
      7'h6F: begin e.cycles = f + 3; e.wb = 2; e.psel = 1; e.imm = 4; end
      7'h67: begin e.cycles = f + 3; e.wb = 2; e.psel = 2; end
      default: e.cycles = f + 2;
    endcase
    e.nreg = (opc inside {7'h13, 7'h33, 7'h37, 7'h17,
                          7'h03, 7'h6F, 7'h67}) ? 1 : 0;
    return e;
  endfunction

  // Entered and left at a falling edge; one instruction from FETCH on
  task automatic run_instr(input logic [6:0] opc, input int tk,
                           input int idl, input int mdl,
                           output obs_t o);
    int fcnt, mcnt, c;
    bit started, left, done;
    o = '{default: 0};
    fcnt = 0; mcnt = 0; c = 0;
    started = 0; left = 0; done = 0;
    ir_opcode = opc;
    branch_taken = tk[0];
    while (!done && c < 60) begin
      if (left && imem_req) begin
        done = 1;
      end else begin
        imem_ready = imem_req && (fcnt >= idl);
        dmem_ready = dmem_req && (mcnt >= mdl);
        #1;
        if (imem_req) begin started = 1; fcnt++; end
        if (started) begin
          o.cycles++;
          if (!imem_req && !left) begin
            left = 1;
            o.imm = int'(imm_sel);
          end
          o.nirwe += int'(ir_we);
          if (dmem_req) begin
            o.dcyc++; mcnt++;
            if (dmem_we) o.dwe = 1;
          end
          if (reg_we) begin o.nreg++; o.wb = int'(wb_sel); end
          if (pc_we) begin o.npc++; o.psel = int'(pc_sel); end
        end
        @(negedge clk);
        c++;
      end
    end
    o.timeout = done ? 0 : 1;
    imem_ready = 1'b0;
    dmem_ready = 1'b0;
  endtask

  task automatic verify(input string tag, input exp_t e, input obs_t o);
    check({tag, " timeout"}, o.timeout, 0);
    check({tag, " cycles"}, o.cycles, e.cycles);
    check({tag, " ir_we"}, o.nirwe, 1);
    check({tag, " reg_we"}, o.nreg, e.nreg);
    if (e.nreg != 0) check({tag, " wb_sel"}, o.wb, e.wb);
    check({tag, " pc_we"}, o.npc, 1);
    check({tag, " pc_sel"}, o.psel, e.psel);
    check({tag, " dmem_req"}, o.dcyc, e.dcyc);
    if (e.dcyc != 0) check({tag, " dmem_we"}, o.dwe, e.dwe);
    check({tag, " imm_sel"}, o.imm, e.imm);
    model_cnt = (model_cnt + 1) % (1 << RW);
    check({tag, " retired"}, int'(retired_cnt), model_cnt);
  endtask

  function automatic int all_out();
    logic [21:0] v;
    v = {imem_req, ir_we, dmem_req, dmem_we, imm_sel, alu_src_a,
         alu_src_b, alu_mode, reg_we, wb_sel, pc_we, pc_sel,
         retired_cnt};
    return int'(v);
  endfunction

  exp_t tbl[11];
  logic [6:0] ops[9];

  initial begin
    obs_t o;
    exp_t e;
    bit ok;
    // opc, tk, idl, mdl, cycles, nreg, wb, psel, dcyc, dwe, imm
    tbl[0]  = '{7'h13, 0, 0, 0, 4, 1, 0, 0, 0, 0, 0};
    tbl[1]  = '{7'h03, 0, 0, 3, 8, 1, 1, 0, 4, 0, 0};
    tbl[2]  = '{7'h23, 0, 0, 0, 4, 0, 0, 0, 1, 1, 1};
    tbl[3]  = '{7'h63, 1, 0, 0, 3, 0, 0, 1, 0, 0, 2};
    tbl[4]  = '{7'h63, 0, 0, 0, 3, 0, 0, 0, 0, 0, 2};
    tbl[5]  = '{7'h67, 0, 0, 0, 4, 1, 2, 2, 0, 0, 0};
    tbl[6]  = '{7'h6F, 0, 0, 0, 4, 1, 2, 1, 0, 0, 4};
    tbl[7]  = '{7'h37, 0, 2, 0, 6, 1, 0, 0, 0, 0, 3};
    tbl[8]  = '{7'h17, 0, 0, 0, 4, 1, 0, 0, 0, 0, 3};
    tbl[9]  = '{7'h33, 0, 0, 0, 4, 1, 0, 0, 0, 0, 0};
    tbl[10] = '{7'h23, 0, 1, 2, 7, 0, 0, 0, 3, 1, 1};
    ops = '{7'h13, 7'h33, 7'h37, 7'h17, 7'h03,
            7'h23, 7'h63, 7'h6F, 7'h67};

    repeat (2) @(negedge clk);
    #1;
    check("reset outputs", all_out(), 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 11; i++) begin
      run_instr(tbl[i].opc, tbl[i].tk, tbl[i].idl, tbl[i].mdl, o);
      verify($sformatf("vec%0d op%02h", i, tbl[i].opc), tbl[i], o);
    end

    for (int i = 0; i < 30; i++) begin
      e = model(ops[$urandom_range(8)], int'($urandom_range(1)),
                int'($urandom_range(2)), int'($urandom_range(3)));
      run_instr(e.opc, e.tk, e.idl, e.mdl, o);
      verify($sformatf("rnd%0d op%02h", i, e.opc), e, o);
    end

    // Reset while a load waits in MEM
    ir_opcode = 7'h03;
    ok = 0;
    for (int c = 0; c < 20 && !ok; c++) begin
      imem_ready = imem_req;
      dmem_ready = 1'b0;
      #1;
      if (dmem_req) ok = 1;
      else @(negedge clk);
    end
    check("lw reaches mem", int'(ok), 1);
    imem_ready = 1'b0;
    @(negedge clk);
    #1;
    check("mem stall req held", int'(dmem_req), 1);
    rst_n = 1'b0;
    #1;
    check("async rst dmem_req", int'(dmem_req), 0);
    check("async rst outputs", all_out(), 0);
    @(negedge clk);
    rst_n = 1'b1;
    model_cnt = 0;
    #1;
    check("idle after rst", all_out(), 0);
    @(negedge clk);
    run_instr(7'h13, 0, 0, 0, o);
    verify("post-rst addi", model(7'h13, 0, 0, 0), o);

`ifdef MULTICYCLE_CTRL_TRAP_EN
    run_instr(7'h7F, 0, 0, 0, o);
    #1;
    check("trap stays", o.timeout, 1);
    check("trap pc_we", o.npc, 0);
    check("trap flag", int'(trap), 1);
    check("trap retired", int'(retired_cnt), model_cnt);
`else
    run_instr(7'h7F, 0, 0, 0, o);
    verify("unknown nop", model(7'h7F, 0, 0, 0), o);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
